// File: rtl/perceptron_pkg.sv
// Shared constants and state encoding for the perceptron sample loader.
package perceptron_pkg;

  localparam int unsigned FEAT_W  = 4;
  localparam int unsigned LBL_BIT = 0;
  localparam int unsigned EOE_BIT = 1;

  typedef enum logic [1:0] {
    IDLE,
    LOAD_FEAT,
    LOAD_LABEL,
    STREAM
  } state_e;

  // Features wider than one nibble clamp to all-ones.
  function automatic logic [FEAT_W-1:0] sat_feat(input logic [7:0] b);
    return (b[7:4] == 4'h0) ? b[FEAT_W-1:0] : '1;
  endfunction

endpackage

// File: rtl/perceptron_strobe_sync.sv
// Two-flop synchroniser for the asynchronous host strobe, plus a one-cycle
// pulse on its synchronised rising edge.
module perceptron_strobe_sync (
  input  logic clk,
  input  logic rst,
  input  logic strobe_i,
  output logic pulse_o
);

  logic meta_q, sync_q, prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= strobe_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign pulse_o = sync_q & ~prev_q;

endmodule

// File: rtl/perceptron_sample_loader.sv
// Assembles host bytes into a small sample buffer and replays it to the
// perceptron core as a valid/ready stream for a fixed number of epochs.
module perceptron_sample_loader
  import perceptron_pkg::*;
#(
  parameter int unsigned INP_DIM  = 2,
  parameter int unsigned DEPTH    = 3,
  parameter int unsigned N_EPOCHS = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [7:0]                  in_data,
  input  logic                        in_strobe,
  input  logic                        clear,
  output logic                        s_valid,
  input  logic                        s_ready,
  output logic [INP_DIM*FEAT_W-1:0]   s_x,
  output logic                        s_y,
  output logic                        s_last,
  output logic                        busy,
  output logic                        done,
  output logic [$clog2(DEPTH+1)-1:0]  sample_cnt,
  output logic                        sat_flag
);

  localparam int unsigned XW = INP_DIM * FEAT_W;
  localparam int unsigned SW = XW + 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned FW = (INP_DIM > 1) ? $clog2(INP_DIM) : 1;
  localparam int unsigned EW = (N_EPOCHS > 1) ? $clog2(N_EPOCHS) : 1;

  state_e          state_q, state_d;
  logic [FW-1:0]   feat_idx_q, feat_idx_d;
  logic [XW-1:0]   feat_q, feat_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [EW-1:0]   epoch_q, epoch_d;
  logic            done_q, done_d;
  logic            sat_q, sat_d;
  logic [SW-1:0]   sbuf_q [DEPTH];

  logic            byte_pulse;
  logic            feat_take;
  logic            wr_en;
  logic            at_last;
  logic [CW-1:0]   cnt_last;
  logic [SW-1:0]   rd_entry;

  perceptron_strobe_sync u_sync (
    .clk      (clk),
    .rst      (rst),
    .strobe_i (in_strobe),
    .pulse_o  (byte_pulse)
  );

  assign cnt_last = cnt_q - CW'(1);
  assign at_last  = (CW'(rd_ptr_q) == cnt_last);

  always_comb begin
    state_d    = state_q;
    feat_idx_d = feat_idx_q;
    feat_d     = feat_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;
    epoch_d    = epoch_q;
    sat_d      = sat_q;
    done_d     = 1'b0;
    wr_en      = 1'b0;
    feat_take  = 1'b0;

    if (clear) begin
      state_d    = IDLE;
      feat_idx_d = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      cnt_d      = '0;
      epoch_d    = '0;
      sat_d      = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          // A retained, non-full buffer is discarded by the first new byte.
          if (byte_pulse && (cnt_q != CW'(DEPTH))) begin
            wr_ptr_d  = '0;
            cnt_d     = '0;
            feat_take = 1'b1;
          end
        end
        LOAD_FEAT: begin
          feat_take = byte_pulse;
        end
        LOAD_LABEL: begin
          if (byte_pulse) begin
            wr_en    = 1'b1;
            cnt_d    = cnt_q + CW'(1);
            wr_ptr_d = wr_ptr_q + PW'(1);
            if (in_data[EOE_BIT] || (cnt_d == CW'(DEPTH))) begin
              state_d  = STREAM;
              rd_ptr_d = '0;
              epoch_d  = '0;
            end else begin
              state_d = LOAD_FEAT;
            end
          end
        end
        STREAM: begin
          if (s_ready) begin
            if (at_last) begin
              rd_ptr_d = '0;
              if ((N_EPOCHS != 0) && (epoch_q == EW'(N_EPOCHS - 1))) begin
                state_d = IDLE;
                epoch_d = '0;
                done_d  = 1'b1;
              end else begin
                epoch_d = epoch_q + EW'(1);
              end
            end else begin
              rd_ptr_d = rd_ptr_q + PW'(1);
            end
          end
        end
        default: state_d = IDLE;
      endcase

      if (feat_take) begin
        feat_d[FEAT_W*feat_idx_q +: FEAT_W] = sat_feat(in_data);
        sat_d = sat_q | (in_data[7:4] != 4'h0);
        if (feat_idx_q == FW'(INP_DIM - 1)) begin
          feat_idx_d = '0;
          state_d    = LOAD_LABEL;
        end else begin
          feat_idx_d = feat_idx_q + FW'(1);
          state_d    = LOAD_FEAT;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      feat_idx_q <= '0;
      feat_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      epoch_q    <= '0;
      done_q     <= 1'b0;
      sat_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      feat_idx_q <= feat_idx_d;
      feat_q     <= feat_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      epoch_q    <= epoch_d;
      done_q     <= done_d;
      sat_q      <= sat_d;
    end
  end

  // Storage needs no reset: entries are only visible while streaming.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      sbuf_q[wr_ptr_q] <= {in_data[LBL_BIT], feat_q};
    end
  end

  assign rd_entry   = sbuf_q[rd_ptr_q];
  assign s_valid    = (state_q == STREAM);
  assign s_x        = s_valid ? rd_entry[XW-1:0] : '0;
  assign s_y        = s_valid & rd_entry[XW];
  assign s_last     = s_valid & at_last;
  assign busy       = (state_q != IDLE);
  assign done       = done_q;
  assign sample_cnt = cnt_q;
  assign sat_flag   = sat_q;

endmodule

// File: tb/tb_perceptron_sample_loader.sv
// Directed bench for perceptron_sample_loader: main instance with 4 epochs,
// second instance with endless replay.
module tb_perceptron_sample_loader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic       in_strobe = 1'b0;
  logic       in_strobe0 = 1'b0;
  logic       clear = 1'b0;
  logic       s_ready = 1'b0;

  logic       s_valid, s_y, s_last, busy, done, sat_flag;
  logic [7:0] s_x;
  logic [1:0] sample_cnt;

  logic       s_valid0, s_y0, s_last0, busy0, done0, sat_flag0;
  logic [7:0] s_x0;
  logic [1:0] sample_cnt0;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  logic [7:0] exp_x [4];
  logic       exp_y [4];

  perceptron_sample_loader #(.INP_DIM(2), .DEPTH(3), .N_EPOCHS(4)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_strobe(in_strobe), .clear(clear),
    .s_valid(s_valid), .s_ready(s_ready), .s_x(s_x), .s_y(s_y), .s_last(s_last),
    .busy(busy), .done(done), .sample_cnt(sample_cnt), .sat_flag(sat_flag)
  );

  perceptron_sample_loader #(.INP_DIM(2), .DEPTH(3), .N_EPOCHS(0)) dut0 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_strobe(in_strobe0), .clear(clear),
    .s_valid(s_valid0), .s_ready(s_ready), .s_x(s_x0), .s_y(s_y0), .s_last(s_last0),
    .busy(busy0), .done(done0), .sample_cnt(sample_cnt0), .sat_flag(sat_flag0)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Strobe held 6 cycles high then 6 low; optionally checks detect->valid latency.
  task automatic send_byte(input logic [7:0] b, input bit sel, input bit lat);
    @(negedge clk);
    in_data = b;
    if (sel) in_strobe0 = 1'b1; else in_strobe = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (lat && i == 2) check("lat_pre", {31'd0, sel ? s_valid0 : s_valid}, 32'd0);
      if (lat && i == 3) check("lat_valid", {31'd0, sel ? s_valid0 : s_valid}, 32'd1);
    end
    in_strobe  = 1'b0;
    in_strobe0 = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic run_stream(input bit sel, input int unsigned n, input int unsigned nsamp,
                            input bit rnd, input bit expect_end, input string tag);
    int unsigned k = 0;
    int unsigned cyc = 0;
    int unsigned dones = 0;
    int unsigned j;
    logic v, y, l, d;
    logic [7:0] x;
    while (k < n && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      s_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      v = sel ? s_valid0 : s_valid;
      x = sel ? s_x0 : s_x;
      y = sel ? s_y0 : s_y;
      l = sel ? s_last0 : s_last;
      d = sel ? done0 : done;
      if (d) dones++;
      if (v) begin
        j = k % nsamp;
        check({tag, "_x"}, {24'd0, x}, {24'd0, exp_x[j]});
        check({tag, "_y"}, {31'd0, y}, {31'd0, exp_y[j]});
        check({tag, "_last"}, {31'd0, l}, {31'd0, (j == nsamp - 1)});
        if (s_ready) k++;
      end
    end
    check({tag, "_beats"}, k, n);
    check({tag, "_early_done"}, dones, 0);
    if (expect_end) begin
      @(negedge clk);
      s_ready = 1'b0;
      check({tag, "_done"}, {31'd0, done}, 32'd1);
      check({tag, "_valid_drop"}, {31'd0, s_valid}, 32'd0);
      check({tag, "_busy_drop"}, {31'd0, busy}, 32'd0);
      @(negedge clk);
      check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_valid", {31'd0, s_valid}, 32'd0);
    check("rst_busy",  {31'd0, busy}, 32'd0);
    check("rst_done",  {31'd0, done}, 32'd0);
    check("rst_cnt",   {30'd0, sample_cnt}, 32'd0);
    check("rst_sat",   {31'd0, sat_flag}, 32'd0);
    check("rst_x",     {24'd0, s_x}, 32'd0);
    check("rst_last",  {31'd0, s_last}, 32'd0);

    // Test 1: three samples fill the buffer, 4 epochs at full rate.
    send_byte(8'h02, 0, 0); send_byte(8'h03, 0, 0); send_byte(8'h00, 0, 0);
    check("t1_busy", {31'd0, busy}, 32'd1);
    send_byte(8'h04, 0, 0); send_byte(8'h05, 0, 0); send_byte(8'h01, 0, 0);
    send_byte(8'h04, 0, 0); send_byte(8'h05, 0, 0); send_byte(8'h01, 0, 1);
    check("t1_cnt", {30'd0, sample_cnt}, 32'd3);
    check("t1_sat", {31'd0, sat_flag}, 32'd0);
    exp_x[0] = 8'h32; exp_y[0] = 1'b0;
    exp_x[1] = 8'h54; exp_y[1] = 1'b1;
    exp_x[2] = 8'h54; exp_y[2] = 1'b1;
    run_stream(0, 12, 3, 0, 1, "t1");

    // Test 2: epoch_end on the second sample.
    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    check("t2_clr_cnt", {30'd0, sample_cnt}, 32'd0);
    send_byte(8'h01, 0, 0); send_byte(8'h02, 0, 0); send_byte(8'h00, 0, 0);
    send_byte(8'h03, 0, 0); send_byte(8'h04, 0, 0); send_byte(8'h03, 0, 0);
    check("t2_valid", {31'd0, s_valid}, 32'd1);
    check("t2_cnt", {30'd0, sample_cnt}, 32'd2);
    exp_x[0] = 8'h21; exp_y[0] = 1'b0;
    exp_x[1] = 8'h43; exp_y[1] = 1'b1;
    run_stream(0, 8, 2, 0, 1, "t2");

    // Test 3: fresh load over the retained buffer, stalled stream.
    send_byte(8'h02, 0, 0);
    check("t3_fresh_cnt", {30'd0, sample_cnt}, 32'd0);
    send_byte(8'h03, 0, 0); send_byte(8'h00, 0, 0);
    send_byte(8'h04, 0, 0); send_byte(8'h05, 0, 0); send_byte(8'h01, 0, 0);
    send_byte(8'h04, 0, 0); send_byte(8'h05, 0, 0); send_byte(8'h01, 0, 0);
    check("t3_cnt", {30'd0, sample_cnt}, 32'd3);
    exp_x[0] = 8'h32; exp_y[0] = 1'b0;
    exp_x[1] = 8'h54; exp_y[1] = 1'b1;
    exp_x[2] = 8'h54; exp_y[2] = 1'b1;
    run_stream(0, 12, 3, 1, 1, "t3");

    // Test 4: full buffer ignores bytes in IDLE; saturation; bytes ignored in STREAM.
    send_byte(8'h09, 0, 0);
    check("t4_full_idle", {31'd0, busy}, 32'd0);
    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    send_byte(8'h27, 0, 0);
    check("t4_sat", {31'd0, sat_flag}, 32'd1);
    send_byte(8'h05, 0, 0); send_byte(8'h01, 0, 0);
    send_byte(8'h06, 0, 0); send_byte(8'h07, 0, 0); send_byte(8'h02, 0, 0);
    check("t4_cnt", {30'd0, sample_cnt}, 32'd2);
    exp_x[0] = 8'h5F; exp_y[0] = 1'b1;
    exp_x[1] = 8'h76; exp_y[1] = 1'b0;
    run_stream(0, 3, 2, 0, 0, "t4");
    @(negedge clk); s_ready = 1'b0;
    send_byte(8'h11, 0, 0);
    check("t4_ign_valid", {31'd0, s_valid}, 32'd1);
    check("t4_ign_x", {24'd0, s_x}, 32'h76);
    check("t4_ign_last", {31'd0, s_last}, 32'd1);
    check("t4_ign_cnt", {30'd0, sample_cnt}, 32'd2);
    check("t4_sat_hold", {31'd0, sat_flag}, 32'd1);

    // Test 5: clear with s_ready in the same cycle.
    @(negedge clk); s_ready = 1'b1; clear = 1'b1;
    @(negedge clk); s_ready = 1'b0; clear = 1'b0;
    check("t5_valid", {31'd0, s_valid}, 32'd0);
    check("t5_cnt", {30'd0, sample_cnt}, 32'd0);
    check("t5_done", {31'd0, done}, 32'd0);
    check("t5_busy", {31'd0, busy}, 32'd0);
    check("t5_sat", {31'd0, sat_flag}, 32'd0);
    @(negedge clk);
    check("t5_done2", {31'd0, done}, 32'd0);

    // Test 6: async reset mid-load, then endless single-sample replay.
    send_byte(8'h01, 0, 0);
    check("t6_loading", {31'd0, busy}, 32'd1);
    @(negedge clk); #2 rst = 1'b1;
    #1;
    check("t6_rst_busy", {31'd0, busy}, 32'd0);
    check("t6_rst_cnt", {30'd0, sample_cnt}, 32'd0);
    check("t6_rst_valid", {31'd0, s_valid}, 32'd0);
    @(negedge clk); rst = 1'b0;
    send_byte(8'h09, 1, 0); send_byte(8'h0A, 1, 0); send_byte(8'h03, 1, 1);
    check("t6_cnt", {30'd0, sample_cnt0}, 32'd1);
    exp_x[0] = 8'hA9; exp_y[0] = 1'b1;
    run_stream(1, 7, 1, 1, 0, "t6");
    @(negedge clk); s_ready = 1'b0;
    check("t6_no_done", {31'd0, done0}, 32'd0);
    check("t6_still_valid", {31'd0, s_valid0}, 32'd1);
    check("t6_main_idle", {31'd0, busy}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
